// File: rtl/sad_best_match.sv
// Accumulates a sum of absolute differences for each candidate block. It then reports
// the candidate with the smallest SAD over a valid/ready result port.
module sad_best_match #(
    parameter int unsigned BLK_PIXELS = 16,
    parameter int unsigned NUM_CAND   = 8,
    parameter int unsigned IDX_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       cur_pix,
    input  logic [7:0]       ref_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      best_sad,
    output logic [IDX_W-1:0] best_idx,
    output logic             busy
);

    localparam int unsigned PIX_W = (BLK_PIXELS > 1) ? $clog2(BLK_PIXELS) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(BLK_PIXELS - 1);
    localparam logic [IDX_W-1:0] CAND_LAST = IDX_W'(NUM_CAND - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, CMP, DONE} state_t;

    state_t           state, state_nxt;
    logic [11:0]      acc;
    logic [PIX_W-1:0] pix_cnt;
    logic [IDX_W-1:0] cand_cnt;
    logic [7:0]       diff;
    logic [11:0]      acc_sum;
    logic             accept;
    logic             new_best;

    assign diff     = (cur_pix >= ref_pix) ? (cur_pix - ref_pix) : (ref_pix - cur_pix);
    assign acc_sum  = acc + {4'b0000, diff};
    assign accept   = in_valid & in_ready;
    // The comparison is strict, so on a tie the earlier candidate keeps the win.
    assign new_best = (cand_cnt == '0) || (acc < best_sad);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (accept && pix_cnt == PIX_LAST) state_nxt = CMP;
            CMP:     state_nxt = (cand_cnt == CAND_LAST) ? DONE : ACCUM;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            pix_cnt  <= '0;
            cand_cnt <= '0;
            best_sad <= '0;
            best_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        pix_cnt  <= '0;
                        cand_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc     <= acc_sum;
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                CMP: begin
                    if (new_best) begin
                        best_sad <= acc;
                        best_idx <= cand_cnt;
                    end
                    if (cand_cnt != CAND_LAST) begin
                        cand_cnt <= cand_cnt + 1'b1;
                        acc      <= '0;
                        pix_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
